// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access.
// Data wins in IDLE, fetches are never preempted, and a watchdog traps hung transactions.
module mem_port_arbiter #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  input  logic              flush,
  output logic              if_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_stall,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DM_BUSY = 3'd1,
    IF_BUSY = 3'd2,
    IF_DROP = 3'd3,
    ERR     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              dm_req_s;
  logic              timeout_s;
  logic              if_valid_s;
  logic              dm_valid_s;

  assign dm_req_s  = dm_rd | dm_wr;
  // The cycle that would bring the count up to TIMEOUT is the one that traps.
  assign timeout_s = (cnt_q == TO_W'(TIMEOUT - 1));

  // State register and registered memory-port drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state, watchdog and strobe logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (dm_req_s) begin
          // A simultaneous read and write is resolved as a write.
          state_d     = DM_BUSY;
          cnt_d       = '0;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_rd_d    = dm_rd & ~dm_wr;
          mem_wr_d    = dm_wr;
        end else if (if_req & ~flush) begin
          state_d    = IF_BUSY;
          cnt_d      = '0;
          mem_addr_d = if_addr;
          mem_rd_d   = 1'b1;
          mem_wr_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      DM_BUSY, IF_DROP: begin
        if (mem_done) begin
          state_d  = IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
        end else if (timeout_s) begin
          state_d  = ERR;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      IF_BUSY: begin
        if (mem_done) begin
          state_d  = IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
        end else if (timeout_s) begin
          state_d  = ERR;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          err_d    = 1'b1;
        end else begin
          // The watchdog keeps running across the move into IF_DROP.
          cnt_d = cnt_q + TO_W'(1);
          if (flush) begin
            state_d = IF_DROP;
          end else begin
            state_d = IF_BUSY;
          end
        end
      end
      ERR: begin
        state_d  = ERR;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        err_d    = 1'b1;
      end
      default: begin
        state_d  = ERR;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        err_d    = 1'b1;
      end
    endcase
  end

  // Completion pulses, gated by the owning state.
  always_comb begin
    if_valid_s = 1'b0;
    dm_valid_s = 1'b0;
    case (state_q)
      DM_BUSY: dm_valid_s = mem_done;
      IF_BUSY: if_valid_s = mem_done & ~flush;
      default: begin
        if_valid_s = 1'b0;
        dm_valid_s = 1'b0;
      end
    endcase
  end

  // Valids are never raised in ERR, so a pending request there always stalls.
  assign if_valid  = if_valid_s;
  assign dm_valid  = dm_valid_s;
  assign if_instr  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign if_stall  = if_req & ~if_valid_s;
  assign dm_stall  = dm_req_s & ~dm_valid_s;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand-built corner sequences and a
// randomized run scored against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, flush, dm_rd, dm_wr, mem_done;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_stall, if_valid, dm_stall, dm_valid, mem_rd, mem_wr, err;
  logic [15:0] if_instr, dm_rdata, mem_addr, mem_wdata;

  int n_pass = 0;
  int n_tot  = 0;

  mem_port_arbiter #(.DATA_W(16), .TIMEOUT(TIMEOUT), .TO_W(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_stall(if_stall), .if_valid(if_valid), .if_instr(if_instr),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_stall(dm_stall), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic ir, input logic [15:0] ia, input logic fl,
                        input logic dr, input logic dw, input logic dn, input logic [15:0] rd);
    if_req = ir; if_addr = ia; flush = fl; dm_rd = dr; dm_wr = dw;
    mem_done = dn; mem_rdata = rd;
  endtask

  // Transaction-level reference: one outstanding job with an age, or the trap.
  bit          m_busy, m_fetch, m_cancel, m_err, m_rd, m_wr;
  int          m_age;
  logic [15:0] m_addr, m_wdata;
  logic        p_dv, p_iv;

  task automatic m_reset();
    m_busy = 0; m_fetch = 0; m_cancel = 0; m_err = 0; m_rd = 0; m_wr = 0;
    m_age = 0; m_addr = 16'h0000; m_wdata = 16'h0000; p_dv = 1'b0; p_iv = 1'b0;
  endtask

  task automatic m_advance();
    if (m_err) begin
      m_rd = 0; m_wr = 0;
    end else if (!m_busy) begin
      if (dm_rd || dm_wr) begin
        m_busy = 1; m_fetch = 0; m_cancel = 0; m_age = 0;
        m_addr = dm_addr; m_wdata = dm_wdata; m_wr = dm_wr; m_rd = dm_rd && !dm_wr;
      end else if (if_req && !flush) begin
        m_busy = 1; m_fetch = 1; m_cancel = 0; m_age = 0;
        m_addr = if_addr; m_rd = 1; m_wr = 0;
      end
    end else if (mem_done) begin
      m_busy = 0; m_rd = 0; m_wr = 0;
    end else begin
      m_age++;
      if (m_age == TIMEOUT) begin
        m_err = 1; m_busy = 0; m_rd = 0; m_wr = 0;
      end else if (m_fetch && flush) begin
        m_cancel = 1;
      end
    end
  endtask

  task automatic rstep();
    logic pdv, piv;
    pdv = !m_err && m_busy && !m_fetch && mem_done;
    piv = !m_err && m_busy && m_fetch && !m_cancel && mem_done && !flush;
    #1;
    chk1("r_mem_rd", mem_rd, m_rd);
    chk1("r_mem_wr", mem_wr, m_wr);
    chk16("r_mem_addr", mem_addr, m_addr);
    chk16("r_mem_wdata", mem_wdata, m_wdata);
    chk1("r_err", err, m_err);
    chk1("r_dm_valid", dm_valid, pdv);
    chk1("r_if_valid", if_valid, piv);
    chk1("r_dm_stall", dm_stall, (dm_rd || dm_wr) && !pdv);
    chk1("r_if_stall", if_stall, if_req && !piv);
    if (pdv) chk16("r_dm_rdata", dm_rdata, mem_rdata);
    if (piv) chk16("r_if_instr", if_instr, mem_rdata);
    p_dv = pdv; p_iv = piv;
    @(posedge clk);
    m_advance();
    @(negedge clk);
  endtask

  typedef struct {
    logic        ir; logic [15:0] ia; logic fl;
    logic        dr, dw; logic [15:0] da, dwd;
    logic        dn; logic [15:0] rd;
    logic        e_rd, e_wr; logic [15:0] e_addr, e_wdata;
    logic        e_iv, e_is, e_dv, e_ds;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [15:0] ia, input logic fl,
                              input logic dr, input logic dw, input logic [15:0] da,
                              input logic [15:0] dwd, input logic dn, input logic [15:0] rd,
                              input logic e_rd, input logic e_wr, input logic [15:0] e_addr,
                              input logic [15:0] e_wdata, input logic e_iv, input logic e_is,
                              input logic e_dv, input logic e_ds);
    vec_t v;
    v.ir = ir; v.ia = ia; v.fl = fl; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.dn = dn; v.rd = rd; v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_iv = e_iv; v.e_is = e_is; v.e_dv = e_dv; v.e_ds = e_ds;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    vec_t v;
    logic [15:0] r16;
    int r;

    // single fetch, mem_done on the third mem_rd cycle
    vecs.push_back(mk(1,16'h0010,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,0,16'h0000,16'h0000, 0,1,0,0));
    vecs.push_back(mk(1,16'h0010,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 1,0,16'h0010,16'h0000, 0,1,0,0));
    vecs.push_back(mk(1,16'h0010,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 1,0,16'h0010,16'h0000, 0,1,0,0));
    vecs.push_back(mk(1,16'h0010,0, 0,0,16'h0000,16'h0000, 1,16'hC123, 1,0,16'h0010,16'h0000, 1,0,0,0));
    vecs.push_back(mk(0,16'h0010,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,0,16'h0010,16'h0000, 0,0,0,0));
    // data vs fetch conflict, then the turnaround IDLE cycle
    vecs.push_back(mk(1,16'h0020,0, 1,0,16'h0200,16'h0000, 0,16'h0000, 0,0,16'h0010,16'h0000, 0,1,0,1));
    vecs.push_back(mk(1,16'h0020,0, 1,0,16'h0200,16'h0000, 0,16'h0000, 1,0,16'h0200,16'h0000, 0,1,0,1));
    vecs.push_back(mk(1,16'h0020,0, 1,0,16'h0200,16'h0000, 1,16'h1111, 1,0,16'h0200,16'h0000, 0,1,1,0));
    vecs.push_back(mk(1,16'h0020,0, 0,0,16'h0200,16'h0000, 0,16'h0000, 0,0,16'h0200,16'h0000, 0,1,0,0));
    vecs.push_back(mk(1,16'h0020,0, 0,0,16'h0200,16'h0000, 0,16'h0000, 1,0,16'h0020,16'h0000, 0,1,0,0));
    vecs.push_back(mk(1,16'h0020,0, 0,0,16'h0200,16'h0000, 1,16'h2222, 1,0,16'h0020,16'h0000, 1,0,0,0));
    vecs.push_back(mk(0,16'h0020,0, 0,0,16'h0200,16'h0000, 0,16'h0000, 0,0,16'h0020,16'h0000, 0,0,0,0));
    // store
    vecs.push_back(mk(0,16'h0020,0, 0,1,16'h0044,16'hBEEF, 0,16'h0000, 0,0,16'h0020,16'h0000, 0,0,0,1));
    vecs.push_back(mk(0,16'h0020,0, 0,1,16'h0044,16'hBEEF, 0,16'h0000, 0,1,16'h0044,16'hBEEF, 0,0,0,1));
    vecs.push_back(mk(0,16'h0020,0, 0,1,16'h0044,16'hBEEF, 0,16'h0000, 0,1,16'h0044,16'hBEEF, 0,0,0,1));
    vecs.push_back(mk(0,16'h0020,0, 0,1,16'h0044,16'hBEEF, 1,16'h3333, 0,1,16'h0044,16'hBEEF, 0,0,1,0));
    vecs.push_back(mk(0,16'h0020,0, 0,0,16'h0044,16'hBEEF, 0,16'h0000, 0,0,16'h0044,16'hBEEF, 0,0,0,0));
    // read+write together resolves as a write
    vecs.push_back(mk(0,16'h0020,0, 1,1,16'h0066,16'h1234, 0,16'h0000, 0,0,16'h0044,16'hBEEF, 0,0,0,1));
    vecs.push_back(mk(0,16'h0020,0, 1,1,16'h0066,16'h1234, 0,16'h0000, 0,1,16'h0066,16'h1234, 0,0,0,1));
    vecs.push_back(mk(0,16'h0020,0, 1,1,16'h0066,16'h1234, 1,16'h4444, 0,1,16'h0066,16'h1234, 0,0,1,0));
    vecs.push_back(mk(0,16'h0020,0, 0,0,16'h0066,16'h1234, 0,16'h0000, 0,0,16'h0066,16'h1234, 0,0,0,0));
    // mem_done while IDLE is ignored
    vecs.push_back(mk(0,16'h0020,0, 0,0,16'h0066,16'h1234, 1,16'h5555, 0,0,16'h0066,16'h1234, 0,0,0,0));
    vecs.push_back(mk(0,16'h0020,0, 0,0,16'h0066,16'h1234, 0,16'h0000, 0,0,16'h0066,16'h1234, 0,0,0,0));
    // flush in IDLE blocks the fetch start
    vecs.push_back(mk(1,16'h0070,1, 0,0,16'h0066,16'h1234, 0,16'h0000, 0,0,16'h0066,16'h1234, 0,1,0,0));
    vecs.push_back(mk(1,16'h0070,0, 0,0,16'h0066,16'h1234, 0,16'h0000, 0,0,16'h0066,16'h1234, 0,1,0,0));
    vecs.push_back(mk(1,16'h0070,0, 0,0,16'h0066,16'h1234, 0,16'h0000, 1,0,16'h0070,16'h1234, 0,1,0,0));
    vecs.push_back(mk(1,16'h0070,0, 0,0,16'h0066,16'h1234, 1,16'h6666, 1,0,16'h0070,16'h1234, 1,0,0,0));
    vecs.push_back(mk(0,16'h0070,0, 0,0,16'h0066,16'h1234, 0,16'h0000, 0,0,16'h0070,16'h1234, 0,0,0,0));

    // reset state
    rst = 1'b0;
    set_in(1, 16'h0000, 0, 0, 0, 1, 16'h0000);
    dm_addr = 16'h0000; dm_wdata = 16'h0000;
    #3;
    chk1("rst_mem_rd", mem_rd, 1'b0);
    chk1("rst_mem_wr", mem_wr, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk16("rst_mem_addr", mem_addr, 16'h0000);
    chk16("rst_mem_wdata", mem_wdata, 16'h0000);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_if_stall", if_stall, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    tick();

    // vector table
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      set_in(v.ir, v.ia, v.fl, v.dr, v.dw, v.dn, v.rd);
      dm_addr = v.da; dm_wdata = v.dwd;
      #1;
      chk1($sformatf("v%0d_mem_rd", i), mem_rd, v.e_rd);
      chk1($sformatf("v%0d_mem_wr", i), mem_wr, v.e_wr);
      chk16($sformatf("v%0d_mem_addr", i), mem_addr, v.e_addr);
      chk16($sformatf("v%0d_mem_wdata", i), mem_wdata, v.e_wdata);
      chk1($sformatf("v%0d_if_valid", i), if_valid, v.e_iv);
      chk1($sformatf("v%0d_if_stall", i), if_stall, v.e_is);
      chk1($sformatf("v%0d_dm_valid", i), dm_valid, v.e_dv);
      chk1($sformatf("v%0d_dm_stall", i), dm_stall, v.e_ds);
      if (v.e_iv) chk16($sformatf("v%0d_if_instr", i), if_instr, v.rd);
      if (v.e_dv) chk16($sformatf("v%0d_dm_rdata", i), dm_rdata, v.rd);
      tick();
    end

    // flush during fetch, done two cycles later: dropped
    set_in(1, 16'h0030, 0, 0, 0, 0, 16'h0000); #1; chk1("fl0_mem_rd", mem_rd, 1'b0); tick();
    set_in(1, 16'h0030, 1, 0, 0, 0, 16'h0000); #1;
    chk1("fl1_mem_rd", mem_rd, 1'b1); chk16("fl1_addr", mem_addr, 16'h0030);
    chk1("fl1_if_valid", if_valid, 1'b0); tick();
    set_in(1, 16'h0040, 0, 0, 0, 0, 16'h0000); #1; chk1("fl2_mem_rd", mem_rd, 1'b1); tick();
    set_in(1, 16'h0040, 0, 0, 0, 1, 16'h7777); #1;
    chk1("fl3_if_valid", if_valid, 1'b0); chk1("fl3_if_stall", if_stall, 1'b1); tick();
    set_in(1, 16'h0040, 0, 0, 0, 0, 16'h0000); #1; chk1("fl4_mem_rd", mem_rd, 1'b0); tick();
    // flush coincident with done
    set_in(1, 16'h0040, 1, 0, 0, 1, 16'h8888); #1;
    chk1("fl5_mem_rd", mem_rd, 1'b1); chk16("fl5_addr", mem_addr, 16'h0040);
    chk1("fl5_if_valid", if_valid, 1'b0); chk1("fl5_if_stall", if_stall, 1'b1); tick();
    set_in(0, 16'h0040, 0, 0, 0, 0, 16'h0000); #1; chk1("fl6_mem_rd", mem_rd, 1'b0); tick();

    // asynchronous reset in the middle of a store
    dm_addr = 16'h0088; dm_wdata = 16'hAAAA;
    set_in(0, 16'h0000, 0, 0, 1, 0, 16'h0000); #1; tick();
    #1; chk1("ar_mem_wr_before", mem_wr, 1'b1);
    #2; rst = 1'b0; #1;
    chk1("ar_mem_wr", mem_wr, 1'b0); chk1("ar_mem_rd", mem_rd, 1'b0); chk1("ar_err", err, 1'b0);
    chk16("ar_mem_addr", mem_addr, 16'h0000);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    set_in(0, 16'h0000, 0, 0, 0, 1, 16'h9999); #1;
    chk1("ar_idle_dm_valid", dm_valid, 1'b0); tick();
    #1; chk1("ar_idle_mem_wr", mem_wr, 1'b0); chk1("ar_idle_mem_rd", mem_rd, 1'b0); tick();

    // randomized run against the reference model
    rst = 1'b0; tick(); rst = 1'b1;
    m_reset();
    set_in(0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    dm_addr = 16'h0000; dm_wdata = 16'h0000;
    for (int c = 0; c < 600; c++) begin
      if (p_dv) begin
        dm_rd = 1'b0; dm_wr = 1'b0;
      end else if (!dm_rd && !dm_wr && ($urandom % 4) == 0) begin
        r = int'($urandom % 16);
        dm_rd = (r < 7) || (r == 15);
        dm_wr = (r >= 7);
        r16 = 16'($urandom); dm_addr = r16;
        r16 = 16'($urandom); dm_wdata = r16;
      end
      if (p_iv) begin
        if_req = 1'b0;
      end else if (!if_req && ($urandom % 3) == 0) begin
        if_req = 1'b1;
        r16 = 16'($urandom); if_addr = r16;
      end
      flush = if_req && (($urandom % 8) == 0);
      if (flush) begin
        r16 = 16'($urandom); if_addr = r16;
      end
      if (m_busy && !m_err) mem_done = (m_age >= 10) || (($urandom % 3) == 0);
      else mem_done = (($urandom % 5) == 0);
      r16 = 16'($urandom); mem_rdata = r16;
      rstep();
    end

    // watchdog: a fetch that never completes
    rst = 1'b0; tick(); rst = 1'b1;
    dm_addr = 16'h0000; dm_wdata = 16'h0000;
    set_in(1, 16'h0050, 0, 0, 0, 0, 16'h0000); #1; tick();
    for (int k = 1; k <= TIMEOUT; k++) begin
      #1;
      chk1($sformatf("to%0d_mem_rd", k), mem_rd, 1'b1);
      chk1($sformatf("to%0d_err", k), err, 1'b0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      mem_done = (k % 2 == 1);
      dm_rd = (k >= 2);
      #1;
      chk1($sformatf("err%0d_err", k), err, 1'b1);
      chk1($sformatf("err%0d_mem_rd", k), mem_rd, 1'b0);
      chk1($sformatf("err%0d_if_stall", k), if_stall, 1'b1);
      chk1($sformatf("err%0d_if_valid", k), if_valid, 1'b0);
      chk1($sformatf("err%0d_dm_stall", k), dm_stall, dm_rd);
      tick();
    end
    #2; rst = 1'b0; #1;
    chk1("err_clr", err, 1'b0);
    chk1("err_clr_mem_rd", mem_rd, 1'b0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    set_in(0, 16'h0000, 0, 0, 0, 0, 16'h0000); #1;
    chk1("post_err", err, 1'b0); tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port between instruction fetch (IF) and data access (MEM stage) in the 16-bit five-stage pipeline.
- Grants one transaction at a time, with data priority over fetch.
- Generates per-requester stall signals that freeze the pipeline, and discards fetches cancelled by a branch/jump flush.
- Includes a watchdog that traps hung memory transactions.

Parameters:
- DATA_W, 16, width of addresses and data.
- TIMEOUT, 15, maximum cycles a transaction may stay outstanding before ERR.
- TO_W, 4, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- if_req  in  1  fetch request, held until serviced.
- if_addr  in  DATA_W  fetch PC.
- flush  in  1  branch/jump redirect; cancels the current fetch.
- if_stall  out  1  freeze PC and IF/ID.
- if_valid  out  1  one-cycle fetch completion.
- if_instr  out  DATA_W  fetched instruction, qualified by if_valid.
- dm_rd  in  1  data load request, held until serviced.
- dm_wr  in  1  data store request, held until serviced.
- dm_addr  in  DATA_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_stall  out  1  freeze the pipeline at the MEM stage.
- dm_valid  out  1  one-cycle data completion.
- dm_rdata  out  DATA_W  load data, qualified by dm_valid.
- mem_rd  out  1  memory read strobe, held for the whole transaction.
- mem_wr  out  1  memory write strobe, held for the whole transaction.
- mem_addr  out  DATA_W  registered memory address.
- mem_wdata  out  DATA_W  registered store data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_done.
- mem_done  in  1  one-cycle transaction completion.
- err  out  1  sticky timeout flag.

Behaviour:
- States: IDLE, DM_BUSY, IF_BUSY, IF_DROP, ERR.
- Reset (rst low, asynchronous):
  - state IDLE, counter 0.
  - mem_rd, mem_wr, mem_addr, mem_wdata all 0.
  - err 0.
  - if_valid and dm_valid 0 (these are combinational and gated by state).
- IDLE:
  - If dm_rd|dm_wr: register dm_addr/dm_wdata into mem_addr/mem_wdata, set mem_rd=dm_rd and mem_wr=dm_wr, go DM_BUSY.
  - Else if if_req & ~flush: register if_addr, set mem_rd=1, go IF_BUSY.
  - Strobes appear on the cycle after the request is sampled.
  - mem_done in IDLE is ignored.
  - dm_rd & dm_wr together is illegal; treat it as a write.
- DM_BUSY: mem_* stay stable. On mem_done:
  - Clear strobes, go IDLE.
  - dm_valid=1 that cycle and dm_rdata=mem_rdata (combinational pass-through).
  - Data transactions are never cancelled; flush does not affect them.
- IF_BUSY:
  - On mem_done & ~flush: if_valid=1, if_instr=mem_rdata, go IDLE.
  - On mem_done & flush: completion is discarded (if_valid=0), go IDLE.
  - On flush without mem_done: go IF_DROP.
- IF_DROP: wait for mem_done; then clear strobes, go IDLE, no if_valid.
- Stalls (combinational):
  - dm_stall = (dm_rd|dm_wr) & ~dm_valid.
  - if_stall = if_req & ~if_valid.
  - Both are forced to 1 in ERR whenever their request is present.
- Priority:
  - In IDLE, data beats fetch; if_stall stays high while the data transaction runs.
  - A fetch already in IF_BUSY is never preempted.
- Turnaround: there is always exactly one IDLE cycle between transactions, so back-to-back requests see 1 extra stall cycle.
- Watchdog:
  - The counter clears on entering DM_BUSY, IF_BUSY or IF_DROP (IF_BUSY→IF_DROP does not clear it).
  - It increments each cycle without mem_done.
  - When it reaches TIMEOUT: go ERR, clear strobes, err=1.
  - ERR is left only by reset.
- Reset mid-transaction: strobes drop immediately and the in-flight result is lost; the memory is reset by the same rst.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0010, mem_done 3 cycles after mem_rd rises, mem_rdata=0xC123. Required: mem_rd high 3 cycles, then if_valid one cycle with if_instr=0xC123; if_stall=1 until that cycle.
- Conflict: dm_rd (addr 0x0200) and if_req asserted in the same IDLE cycle. Required: mem_addr=0x0200 first; dm_valid, then one IDLE cycle, then mem_addr=if_addr; if_stall high throughout.
- Store: dm_wr=1, dm_addr=0x0044, dm_wdata=0xBEEF. Required: mem_wr=1, mem_wdata=0xBEEF stable until mem_done; dm_valid pulses; mem_rd never asserted.
- Flush: flush during IF_BUSY, mem_done 2 cycles later. Required: state IF_DROP, no if_valid. Repeat with flush coincident with mem_done: still no if_valid.
- Timeout: TIMEOUT=15, start a fetch, never assert mem_done. Required: after 15 cycles err=1, mem_rd=0, if_stall=1; this persists until rst is pulled low.
- Async reset: pull rst low mid-DM_BUSY between clock edges. Required: mem_rd/mem_wr/err drop to 0 immediately, state IDLE after release.
